// File: rtl/char_writer_pkg.sv
// Shared types and character codes for the text-mode character writer.
package char_writer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PUT,
    SCR_RD,
    SCR_WR,
    CLR
  } state_t;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CH_SPACE) && (c <= CH_TILDE);
  endfunction

endpackage

// File: rtl/char_writer.sv
// Character writer: turns a stream of character codes into text-RAM writes with cursor tracking.
// Build option CHAR_WRITER_SCROLL_EN: scroll the screen up instead of wrapping to row 0.
//
// state  | meaning
// IDLE   | waiting for a character (in_ready high)
// PUT    | writing one cell at the cursor
// SCR_RD | scroll: reading source cell ptr+COLS
// SCR_WR | scroll: writing read data to cell ptr
// CLR    | blanking cells ptr..ptr+cnt, one per cycle
module char_writer
  import char_writer_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int AW   = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_char,
  output logic          vram_we,
  output logic [AW-1:0] vram_addr,
  output logic [7:0]    vram_din,
  input  logic [7:0]    vram_dout,
  output logic [6:0]    cur_x,
  output logic [4:0]    cur_y,
  output logic          busy
);

  localparam logic [AW-1:0] ONE_A    = AW'(1);
  localparam logic [AW-1:0] COLS_A   = AW'(COLS);
  localparam logic [AW-1:0] CELLS_M1 = AW'(COLS * ROWS - 1);
  localparam logic [AW-1:0] ROW_M1   = AW'(COLS - 1);
  localparam logic [6:0]    X_MAX    = 7'(COLS - 1);
  localparam logic [4:0]    Y_MAX    = 5'(ROWS - 1);
`ifdef CHAR_WRITER_SCROLL_EN
  localparam logic [AW-1:0] SCR_M1   = AW'(COLS * (ROWS - 1) - 1);
  localparam state_t        WRAP_ST  = SCR_RD;
`else
  localparam state_t        WRAP_ST  = CLR;
  logic unused_dout;
  assign unused_dout = ^vram_dout;
`endif

  state_t        state, state_n;
  logic          run;
  logic [AW-1:0] ptr;
  logic [AW-1:0] cnt;
  logic [7:0]    chr;
  logic          adv;

  logic          hs, last_col, last_row, nl, wrap, put_go, ff_go, cnt_tc;
  logic [AW-1:0] cur_addr;

  // run stays low for the first cycle after reset so nothing is written while rst_n is low
  assign hs       = run && (state == IDLE) && in_valid;
  assign last_col = (cur_x == X_MAX);
  assign last_row = (cur_y == Y_MAX);
  assign nl       = (hs && (in_char == CH_LF)) || ((state == PUT) && adv && last_col);
  assign wrap     = nl && last_row;
  assign put_go   = hs && (is_printable(in_char) || ((in_char == CH_BS) && (cur_x != 7'd0)));
  assign ff_go    = hs && (in_char == CH_FF);
  assign cnt_tc   = (cnt == '0);
  assign cur_addr = AW'(cur_y) * COLS_A + AW'(cur_x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLR;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (run) begin
      case (state)
        IDLE: begin
          if (ff_go)       state_n = CLR;
          else if (put_go) state_n = PUT;
          else if (wrap)   state_n = WRAP_ST;
        end
        PUT:    state_n = wrap ? WRAP_ST : IDLE;
`ifdef CHAR_WRITER_SCROLL_EN
        SCR_RD: state_n = SCR_WR;
        SCR_WR: state_n = cnt_tc ? CLR : SCR_RD;
`endif
        CLR:    if (cnt_tc) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = run && (state == IDLE);
    busy      = (state != IDLE);
    vram_we   = 1'b0;
    vram_addr = ptr;
    vram_din  = CH_SPACE;
    case (state)
      PUT: begin
        vram_we   = run;
        vram_addr = cur_addr;
        vram_din  = chr;
      end
`ifdef CHAR_WRITER_SCROLL_EN
      SCR_RD: vram_addr = ptr + COLS_A;
      SCR_WR: begin
        vram_we  = run;
        vram_din = vram_dout;
      end
`endif
      CLR: vram_we = run;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      cur_x <= '0;
      cur_y <= '0;
      ptr   <= '0;
      cnt   <= CELLS_M1;
      chr   <= CH_SPACE;
      adv   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) begin
        case (state)
          IDLE: begin
            if (hs) begin
              if (in_char == CH_FF) begin
                cur_x <= '0;
                cur_y <= '0;
                ptr   <= '0;
                cnt   <= CELLS_M1;
              end else if (is_printable(in_char)) begin
                chr <= in_char;
                adv <= 1'b1;
              end else if ((in_char == CH_BS) && (cur_x != 7'd0)) begin
                chr   <= CH_SPACE;
                adv   <= 1'b0;
                cur_x <= cur_x - 7'd1;
              end else if (in_char == CH_CR) begin
                cur_x <= '0;
              end
            end
          end
          PUT: if (adv && !last_col) cur_x <= cur_x + 7'd1;
`ifdef CHAR_WRITER_SCROLL_EN
          // falling out of the copy leaves ptr at the first cell of the last row
          SCR_WR: begin
            ptr <= ptr + ONE_A;
            cnt <= cnt_tc ? ROW_M1 : cnt - ONE_A;
          end
`endif
          CLR: begin
            if (!cnt_tc) begin
              ptr <= ptr + ONE_A;
              cnt <= cnt - ONE_A;
            end
          end
          default: ;
        endcase

        if (nl) begin
          cur_x <= '0;
          if (!last_row) begin
            cur_y <= cur_y + 5'd1;
          end else begin
            ptr <= '0;
`ifdef CHAR_WRITER_SCROLL_EN
            cnt <= SCR_M1;
`else
            cur_y <= '0;
            cnt   <= ROW_M1;
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_char_writer.sv
// Directed self-checking bench for char_writer (80x30 screen, behavioural text RAM).
module tb_char_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic        in_ready;
  logic        vram_we;
  logic [11:0] vram_addr;
  logic [7:0]  vram_din;
  logic [7:0]  vram_dout;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;
  logic        busy;

  int tests = 0;
  int errors = 0;

  char_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_char   (in_char),
    .vram_we   (vram_we),
    .vram_addr (vram_addr),
    .vram_din  (vram_din),
    .vram_dout (vram_dout),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // text RAM with one-cycle read latency; poke/fill let the bench preload cells
  logic [7:0]  mem [0:4095];
  logic        fill_en = 1'b0;
  logic        poke_en = 1'b0;
  logic [11:0] poke_a = '0;
  logic [7:0]  poke_d = '0;
  int          wr_cnt = 0;
  logic [11:0] last_a = '0;
  logic [7:0]  last_d = '0;

  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'hFF;
    end else if (poke_en) begin
      mem[poke_a] <= poke_d;
    end else if (vram_we) begin
      mem[vram_addr] <= vram_din;
    end
    vram_dout <= mem[vram_addr];
    if (vram_we) begin
      wr_cnt <= wr_cnt + 1;
      last_a <= vram_addr;
      last_d <= vram_din;
    end
  end

  task automatic wait_ready(input string what);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      tests++; errors++;
      $display("FAIL %s: in_ready still 0 after %0d cycles", what, t);
    end
  endtask

  task automatic start_char(input logic [7:0] c);
    wait_ready("start_char");
    in_valid = 1'b1;
    in_char  = c;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    start_char(c);
    wait_ready("send");
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic collect_clear(output int n, output int bad);
    int t = 0;
    n = 0; bad = 0;
    while (t < 20000) begin
      @(negedge clk);
      if (vram_we) begin
        if (vram_addr !== 12'(n) || vram_din !== 8'h20) bad++;
        n++;
      end
      if (in_ready) break;
      t++;
    end
  endtask

  task automatic test_reset();
    int n, bad;
    rst_n = 1'b0;
    fill_en = 1'b1;
    @(posedge clk);
    #1 fill_en = 1'b0;
    @(negedge clk);
    tests++; if (vram_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", vram_we); end
    tests++; if (vram_addr !== 12'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", vram_addr); end
    tests++; if (vram_din !== 8'h20) begin errors++; $display("FAIL rst_din: got %0h want 20", vram_din); end
    tests++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", in_ready); end
    tests++; if (cur_x !== 7'd0 || cur_y !== 5'd0) begin errors++; $display("FAIL rst_cursor: got (%0d,%0d) want (0,0)", cur_x, cur_y); end
    rst_n = 1'b1;
    collect_clear(n, bad);
    tests++; if (n !== 2400) begin errors++; $display("FAIL init_clear_count: got %0d want 2400", n); end
    tests++; if (bad !== 0) begin errors++; $display("FAIL init_clear_order: %0d bad writes want 0", bad); end
    tests++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL init_idle: ready=%b busy=%b want 1/0", in_ready, busy); end
    tests++; if (mem[2399] !== 8'h20 || mem[2400] !== 8'hFF) begin errors++; $display("FAIL init_clear_span: m2399=%0h m2400=%0h want 20/ff", mem[2399], mem[2400]); end
  endtask

  task automatic test_print();
    start_char(8'h41);
    tests++; if (vram_we !== 1'b1 || vram_addr !== 12'd0 || vram_din !== 8'h41) begin errors++; $display("FAIL put_A: we=%b addr=%0d din=%0h want 1/0/41", vram_we, vram_addr, vram_din); end
    @(posedge clk);
    #1;
    tests++; if (vram_we !== 1'b0 || cur_x !== 7'd1) begin errors++; $display("FAIL put_A_done: we=%b x=%0d want 0/1", vram_we, cur_x); end
    send(8'h42);
    tests++; if (last_a !== 12'd1 || last_d !== 8'h42) begin errors++; $display("FAIL put_B: addr=%0d din=%0h want 1/42", last_a, last_d); end
    tests++; if (cur_x !== 7'd2 || cur_y !== 5'd0 || mem[0] !== 8'h41) begin errors++; $display("FAIL print_state: (%0d,%0d) m0=%0h want (2,0) 41", cur_x, cur_y, mem[0]); end
  endtask

  task automatic test_control();
    int w;
    send(8'h0D);
    tests++; if (cur_x !== 7'd0 || cur_y !== 5'd0) begin errors++; $display("FAIL cr_row0: got (%0d,%0d) want (0,0)", cur_x, cur_y); end
    send(8'h0A); send(8'h0A);
    send(8'h2E); send(8'h2E); send(8'h2E);
    tests++; if (cur_x !== 7'd3 || cur_y !== 5'd2) begin errors++; $display("FAIL lf_pos: got (%0d,%0d) want (3,2)", cur_x, cur_y); end
    send(8'h08);
    tests++; if (last_a !== 12'd162 || last_d !== 8'h20 || cur_x !== 7'd2 || cur_y !== 5'd2) begin errors++; $display("FAIL bs: addr=%0d din=%0h cur=(%0d,%0d) want 162/20 (2,2)", last_a, last_d, cur_x, cur_y); end
    w = wr_cnt;
    send(8'h0D);
    tests++; if (cur_x !== 7'd0 || cur_y !== 5'd2 || wr_cnt !== w) begin errors++; $display("FAIL cr: cur=(%0d,%0d) writes=%0d want (0,2) 0", cur_x, cur_y, wr_cnt - w); end
    send(8'h08);
    tests++; if (cur_x !== 7'd0 || wr_cnt !== w) begin errors++; $display("FAIL bs_at0: x=%0d writes=%0d want 0/0", cur_x, wr_cnt - w); end
    send(8'h01); send(8'h7F);
    tests++; if (cur_x !== 7'd0 || cur_y !== 5'd2 || wr_cnt !== w) begin errors++; $display("FAIL discard: cur=(%0d,%0d) writes=%0d want (0,2) 0", cur_x, cur_y, wr_cnt - w); end
  endtask

  task automatic test_wrap();
    int n, bad;
    start_char(8'h0C);
    collect_clear(n, bad);
    tests++; if (n !== 2400 || bad !== 0 || cur_x !== 7'd0 || cur_y !== 5'd0) begin errors++; $display("FAIL ff: writes=%0d bad=%0d cur=(%0d,%0d) want 2400/0 (0,0)", n, bad, cur_x, cur_y); end
    for (int i = 0; i < 5; i++) send(8'h0A);
    for (int i = 0; i < 79; i++) send(8'h2E);
    tests++; if (cur_x !== 7'd79 || cur_y !== 5'd5) begin errors++; $display("FAIL pre_wrap: got (%0d,%0d) want (79,5)", cur_x, cur_y); end
    send(8'h5A);
    tests++; if (last_a !== 12'd479 || last_d !== 8'h5A) begin errors++; $display("FAIL wrap_write: addr=%0d din=%0h want 479/5a", last_a, last_d); end
    tests++; if (cur_x !== 7'd0 || cur_y !== 5'd6) begin errors++; $display("FAIL wrap_cursor: got (%0d,%0d) want (0,6)", cur_x, cur_y); end
  endtask

  task automatic test_last_row();
    int w, t;
    send(8'h0C);
    poke(12'd5, 8'h33);
    poke(12'd80, 8'h11);
    poke(12'd2399, 8'h22);
    for (int i = 0; i < 29; i++) send(8'h0A);
    for (int i = 0; i < 10; i++) send(8'h30 + 8'(i));
    tests++; if (cur_x !== 7'd10 || cur_y !== 5'd29) begin errors++; $display("FAIL pre_scroll: got (%0d,%0d) want (10,29)", cur_x, cur_y); end
    wait_ready("last_row");
    w = wr_cnt;
    in_valid = 1'b1;
    in_char  = 8'h0A;
    @(posedge clk);
    #1 in_char = 8'h41;
    t = 0;
    while (t < 20000) begin
      @(negedge clk);
      if (in_ready) break;
      t++;
    end
    in_valid = 1'b0;
    @(negedge clk);
`ifdef CHAR_WRITER_SCROLL_EN
    tests++; if (wr_cnt - w !== 2400) begin errors++; $display("FAIL scroll_writes: got %0d want 2400", wr_cnt - w); end
    tests++; if (mem[0] !== 8'h11 || mem[2319] !== 8'h22 || mem[5] !== 8'h20) begin errors++; $display("FAIL scroll_copy: m0=%0h m2319=%0h m5=%0h want 11/22/20", mem[0], mem[2319], mem[5]); end
    tests++; if (mem[2240] !== 8'h30 || mem[2249] !== 8'h39) begin errors++; $display("FAIL scroll_lastrow_copy: m2240=%0h m2249=%0h want 30/39", mem[2240], mem[2249]); end
    tests++; if (mem[2320] !== 8'h20 || mem[2399] !== 8'h20) begin errors++; $display("FAIL scroll_blank: m2320=%0h m2399=%0h want 20/20", mem[2320], mem[2399]); end
    tests++; if (cur_x !== 7'd0 || cur_y !== 5'd29) begin errors++; $display("FAIL scroll_cursor: got (%0d,%0d) want (0,29)", cur_x, cur_y); end
`else
    tests++; if (wr_cnt - w !== 80) begin errors++; $display("FAIL wrap_row0_writes: got %0d want 80", wr_cnt - w); end
    tests++; if (mem[5] !== 8'h20 || mem[80] !== 8'h11 || mem[2399] !== 8'h22) begin errors++; $display("FAIL wrap_row0_blank: m5=%0h m80=%0h m2399=%0h want 20/11/22", mem[5], mem[80], mem[2399]); end
    tests++; if (mem[2320] !== 8'h30 || mem[2329] !== 8'h39) begin errors++; $display("FAIL wrap_keep_last: m2320=%0h m2329=%0h want 30/39", mem[2320], mem[2329]); end
    tests++; if (cur_x !== 7'd0 || cur_y !== 5'd0) begin errors++; $display("FAIL wrap_row0_cursor: got (%0d,%0d) want (0,0)", cur_x, cur_y); end
`endif
  endtask

  task automatic test_reset_mid();
    int n, bad;
`ifdef CHAR_WRITER_SCROLL_EN
    start_char(8'h0A);
`else
    start_char(8'h0C);
`endif
    repeat (100) @(negedge clk);
    tests++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (vram_we !== 1'b0 || in_ready !== 1'b0 || vram_addr !== 12'd0) begin errors++; $display("FAIL mid_abort: we=%b ready=%b addr=%0d want 0/0/0", vram_we, in_ready, vram_addr); end
    tests++; if (cur_x !== 7'd0 || cur_y !== 5'd0) begin errors++; $display("FAIL mid_cursor: got (%0d,%0d) want (0,0)", cur_x, cur_y); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    collect_clear(n, bad);
    tests++; if (n !== 2400 || bad !== 0) begin errors++; $display("FAIL mid_restart: writes=%0d bad=%0d want 2400/0", n, bad); end
  endtask

  initial begin
    test_reset();
    test_print();
    test_control();
    test_wrap();
    test_last_row();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/char_writer.md
CHAR_WRITER -- requirements
Module: char_writer

Interface
REQ-001 Parameter COLS, default 80, text columns per row.
REQ-002 Parameter ROWS, default 30, text rows per screen.
REQ-003 Parameter AW, default 12, VRAM address width; COLS*ROWS SHALL be at most 2^AW.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  character offered.
REQ-007 in_ready  out  1  writer can accept a character.
REQ-008 in_char  in  8  character code.
REQ-009 vram_we  out  1  text-RAM write strobe, one cycle per cell.
REQ-010 vram_addr  out  AW  cell address = row*COLS + col.
REQ-011 vram_din  out  8  code to write.
REQ-012 vram_dout  in  8  text-RAM read data, valid one cycle after vram_addr.
REQ-013 cur_x  out  7  cursor column.
REQ-014 cur_y  out  5  cursor row.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be: IDLE, PUT, SCR_RD, SCR_WR, CLR.
REQ-017 A handshake SHALL occur when in_valid and in_ready are both high on a clock edge; in_ready SHALL be high only in IDLE.
REQ-018 A printable code (0x20-0x7E) SHALL go IDLE->PUT; PUT SHALL drive vram_we=1, addr=cursor, din=code for one cycle, then advance cur_x and return to IDLE.
REQ-019 Codes SHALL take effect one cycle after the handshake (latency 1); throughput SHALL be at most one character per 2 cycles.
REQ-020 Cursor advance from cur_x=COLS-1 SHALL wrap to cur_x=0, cur_y+1.
REQ-021 0x0D SHALL set cur_x=0 with no write.
REQ-022 0x0A SHALL set cur_x=0, cur_y+1 with no write.
REQ-023 0x08 at cur_x>0 SHALL decrement cur_x and write 0x20 at the new position; at cur_x=0 it SHALL be a no-op.
REQ-024 0x0C SHALL clear the whole screen to 0x20 via CLR and home the cursor to (0,0).
REQ-025 Other codes SHALL be accepted and discarded.
REQ-026 Advance beyond cur_y=ROWS-1 SHALL trigger scroll (see REQ-032), leaving cur_y=ROWS-1, cur_x=0.
REQ-027 Scroll: for each destination cell d in 0..COLS*(ROWS-1)-1, SCR_RD SHALL drive addr=d+COLS, and SCR_WR SHALL write vram_dout to d; CLR SHALL then fill the last row with 0x20.
REQ-028 CLR SHALL write one cell per cycle in ascending address order.
REQ-029 Address arithmetic SHALL be AW bits, with no overflow for legal parameters.

Reset
REQ-030 Reset SHALL set cur_x=0, cur_y=0, vram_we=0, vram_addr=0, vram_din=0x20, and in_ready=0.
REQ-031 After release, the FSM SHALL run a full-screen CLR before the first IDLE; assertion mid-scroll or mid-clear SHALL abort immediately, and the clear SHALL restart on release.

Configuration
REQ-032 With CHAR_WRITER_SCROLL_EN defined, advance past the last row SHALL scroll per REQ-027; without it, the cursor SHALL wrap to row 0, and CLR SHALL blank row 0 only, with SCR_RD/SCR_WR removed.

Structure
REQ-033 Package char_writer_pkg SHALL hold the state enum and code constants (CH_BS, CH_LF, CH_FF, CH_CR, CH_SPACE).
REQ-034 No sub-module is required; cursor and address counters SHALL be inline.

Verification
REQ-035 Reset release -> 2400 writes of 0x20 to addresses 0..2399, then in_ready=1 and cursor (0,0).
REQ-036 Send 'A' (0x41) then 'B' -> writes 0x41@0 and 0x42@1, cur_x=2.
REQ-037 Cursor (79,5), send 0x5A -> write @479, cursor (0,6).
REQ-038 Cursor (3,2), send 0x08 -> write 0x20@162, cursor (2,2); then 0x0D -> cursor (0,2), no write.
REQ-039 Scroll enabled, cursor (10,29), send 0x0A -> RAM cell 80 copied to 0, cell 2399 copied to 2319, row 29 blanked, cursor (0,29); in_valid held high throughout -> no accept until IDLE.
REQ-040 Assert rst_n mid-scroll -> vram_we=0 immediately; release -> full clear restarts.
